bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter. It turns a binary measurement (for example, a distance count from the cart sensor logic) into four packed BCD digits. Its output feeds the 16-bit `nums` input of the seven-segment display driver directly. It uses shift-and-add-3 (double-dabble), one bit per clock, with a start/busy/done handshake. The last result is held stable on the output between conversions.

---
 rtl/bin_to_bcd_seq.sv | 103 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Produces four packed BCD digits for the seven-segment display driver.
// The last result is held on nums/ovf between conversions.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [15:0]      nums,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Saturation limit, both as a plain number and as packed BCD digits
  localparam logic [31:0] MAX_U   = 32'(MAX_VAL);
  localparam logic [15:0] MAX_BCD = {4'((MAX_VAL / 1000) % 10),
                                     4'((MAX_VAL / 100) % 10),
                                     4'((MAX_VAL / 10) % 10),
                                     4'(MAX_VAL % 10)};

  state_t           state, state_next;
  logic [BIN_W-1:0] bin_sr;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [3:0]       cnt;
  logic             sat;
  logic [31:0]      bin_ext;

  assign bin_ext = 32'(bin_in);
  assign busy    = (state != IDLE);

  // Add-3 adjust on every nibble that is 5 or more, all nibbles in parallel
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave SHIFT on the edge where the counter goes 1 to 0
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == 4'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift while converting, publish the result once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_sr <= '0;
      bcd    <= '0;
      cnt    <= '0;
      sat    <= 1'b0;
      nums   <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd    <= '0;
            cnt    <= 4'(BIN_W);
            sat    <= (bin_ext > MAX_U);
          end
        end
        SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
          cnt           <= cnt - 4'd1;
        end
        DONE: begin
          nums <= sat ? MAX_BCD : bcd;
          ovf  <= sat;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes hand-computed
// expectations, a monitor pops and compares whenever done pulses.
module tb_bin_to_bcd_seq;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic [13:0] bin_in = '0;
  logic [15:0] nums;
  logic        busy;
  logic        done;
  logic        ovf;

  typedef struct {
    logic [15:0] nums;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          done_count  = 0;
  logic [15:0] model_nums  = '0;
  logic        model_ovf   = 1'b0;

  bin_to_bcd_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .nums   (nums),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issue one start pulse and record the expected result and its done cycle
  task automatic applyStimulus(input logic [13:0] v, input logic [15:0] exp_nums, input logic exp_ovf);
    exp_t e;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    e.nums = exp_nums;
    e.ovf  = exp_ovf;
    e.cyc  = cyc + 15;
    sb.push_back(e);
    start  = 1'b0;
    bin_in = ~v;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare on done, otherwise the outputs must hold the last result
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_count++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("result_nums", 32'(nums), 32'(mon_e.nums));
          checkOutput("result_ovf", 32'(ovf), 32'(mon_e.ovf));
          checkOutput("done_cycle", cyc, mon_e.cyc);
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          model_nums = mon_e.nums;
          model_ovf  = mon_e.ovf;
        end
      end else begin
        checkOutput("held_nums", 32'(nums), 32'(model_nums));
        checkOutput("held_ovf", 32'(ovf), 32'(model_ovf));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100000ns, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int n;
    int dc;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_nums", 32'(nums), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    #30 rst = 1'b1;

    // Zero, with busy counted over the conversion
    applyStimulus(14'd0, 16'h0000, 1'b0);
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    checkOutput("busy_cycles", n, 15);
    waitDrain(40);

    // Ordinary values
    applyStimulus(14'd1234, 16'h1234, 1'b0);
    waitDrain(40);
    applyStimulus(14'd9999, 16'h9999, 1'b0);
    waitDrain(40);
    applyStimulus(14'd507, 16'h0507, 1'b0);
    waitDrain(40);

    // Saturation and recovery
    applyStimulus(14'd10000, 16'h9999, 1'b1);
    waitDrain(40);
    applyStimulus(14'd16383, 16'h9999, 1'b1);
    waitDrain(40);
    applyStimulus(14'd42, 16'h0042, 1'b0);
    waitDrain(40);

    // Start pulses while busy at T3 and T14 are ignored
    dc = done_count;
    applyStimulus(14'd321, 16'h0321, 1'b0);
    repeat (3) @(negedge clk);
    bin_in = 14'd888;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    bin_in = 14'd888;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDrain(40);
    repeat (20) @(negedge clk);
    checkOutput("ignored_start_dones", done_count - dc, 1);

    // Start held high: back-to-back conversions every 16 cycles
    @(negedge clk);
    bin_in = 14'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{nums: 16'h0005, ovf: 1'b0, cyc: cyc + 15});
    bin_in = 14'd6;
    repeat (16) @(posedge clk);
    #1;
    sb.push_back('{nums: 16'h0006, ovf: 1'b0, cyc: cyc + 15});
    bin_in = 14'd7;
    repeat (16) @(posedge clk);
    #1;
    sb.push_back('{nums: 16'h0007, ovf: 1'b0, cyc: cyc + 15});
    start = 1'b0;
    waitDrain(60);

    // Reset in the middle of a conversion aborts it
    applyStimulus(14'd4321, 16'h4321, 1'b0);
    waitDrain(40);
    dc = done_count;
    @(negedge clk);
    bin_in = 14'd9876;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst        = 1'b0;
    model_nums = 16'h0000;
    model_ovf  = 1'b0;
    #1;
    checkOutput("abort_nums", 32'(nums), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("abort_idle_busy", 32'(busy), 32'd0);
    checkOutput("abort_no_done", done_count - dc, 0);
    checkOutput("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
